// File: rtl/pokey_audio_n.sv
// pokey_audio_n: N-channel POKEY-style tone/noise generator.
// CPU register file (AUDF/AUDC per channel, AUDCTL, RANDOM), shared poly
// counters, per-channel reload down-counters with tone flops, and a summing
// mixer whose width is scaled so NUM_CH*15 never overflows.
module pokey_audio_n #(
  parameter int NUM_CH   = 4,
  parameter int BASE_DIV = 28,
  parameter int ADDR_W   = 4,
  parameter int OUT_W    = 4 + $clog2(NUM_CH + 1)
) (
  input  logic              phi2,
  input  logic              reset,
  input  logic              cs_n,
  input  logic              r_w_n,
  input  logic [ADDR_W-1:0] a,
  input  logic [7:0]        d_in,
  output logic [7:0]        d_out,
  output logic [OUT_W-1:0]  aud
);

  localparam int PW = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
  localparam logic [PW-1:0]     PRE_LAST = PW'(BASE_DIV - 1);
  localparam logic [ADDR_W-1:0] A_CTL    = ADDR_W'(2 * NUM_CH);
  localparam logic [ADDR_W-1:0] A_RND    = ADDR_W'(2 * NUM_CH + 1);

  logic             wr_en;
  logic             rd_en;
  logic [7:0]       audf [NUM_CH];
  logic [7:0]       audc [NUM_CH];
  logic [7:0]       audctl;
  logic [3:0]       poly4;
  logic [4:0]       poly5;
  logic [8:0]       poly9;
  logic [16:0]      poly17;
  logic [PW-1:0]    presc;
  logic             base_tick;
  logic [7:0]       cnt [NUM_CH];
  logic [NUM_CH-1:0] tone;
  logic [NUM_CH-1:0] gate;
  logic [3:0]       amp [NUM_CH];
  logic             poly_big;
  logic [7:0]       rd_val;
  logic [OUT_W-1:0] mix;

  assign wr_en     = !cs_n && !r_w_n;
  assign rd_en     = !cs_n && r_w_n;
  assign base_tick = (presc == PRE_LAST);
  assign poly_big  = audctl[7] ? poly9[0] : poly17[0];

  // Register file writes; reset wins over a write on the same edge.
  always_ff @(posedge phi2) begin
    if (reset) begin
      audctl <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        audf[c] <= '0;
        audc[c] <= '0;
      end
    end else if (wr_en) begin
      if (a == A_CTL) audctl <= d_in;
      for (int c = 0; c < NUM_CH; c++) begin
        if (a == ADDR_W'(2 * c))     audf[c] <= d_in;
        if (a == ADDR_W'(2 * c + 1)) audc[c] <= d_in;
      end
    end
  end

  // Read mux; unmapped addresses read as zero.
  always_comb begin
    rd_val = '0;
    if (a == A_CTL) rd_val = audctl;
    if (a == A_RND) rd_val = audctl[7] ? poly9[7:0] : poly17[7:0];
    for (int c = 0; c < NUM_CH; c++) begin
      if (a == ADDR_W'(2 * c))     rd_val = audf[c];
      if (a == ADDR_W'(2 * c + 1)) rd_val = audc[c];
    end
  end

  // Registered read data, held between reads.
  always_ff @(posedge phi2) begin
    if (reset)      d_out <= '0;
    else if (rd_en) d_out <= rd_val;
  end

  // Fibonacci polys shifting right; new bit enters at the top, output is bit 0.
  always_ff @(posedge phi2) begin
    if (reset) begin
      poly4  <= '1;
      poly5  <= '1;
      poly9  <= '1;
      poly17 <= '1;
    end else begin
      poly4  <= {poly4[0] ^ poly4[3], poly4[3:1]};
      poly5  <= {poly5[0] ^ poly5[3], poly5[4:1]};
      poly9  <= {poly9[0] ^ poly9[4], poly9[8:1]};
      poly17 <= {poly17[0] ^ poly17[12], poly17[16:1]};
    end
  end

  // Base-tick prescaler cycling 0..BASE_DIV-1.
  always_ff @(posedge phi2) begin
    if (reset)                  presc <= '0;
    else if (presc == PRE_LAST) presc <= '0;
    else                        presc <= presc + 1'b1;
  end

  // Per-channel noise gate and output amplitude.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      gate[c] = audc[c][5] |
                ((audc[c][7] | poly5[0]) & (audc[c][6] ? poly4[0] : poly_big));
      amp[c]  = (audc[c][4] | tone[c]) ? audc[c][3:0] : 4'd0;
    end
  end

  // Channel counters: reload from AUDF on terminal count, never force-loaded by a write.
  always_ff @(posedge phi2) begin
    if (reset) begin
      tone <= '0;
      for (int c = 0; c < NUM_CH; c++) cnt[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (audctl[c] | base_tick) begin
          if (cnt[c] == 8'd0) begin
            cnt[c] <= audf[c];
            if (gate[c]) tone[c] <= ~tone[c];
          end else begin
            cnt[c] <= cnt[c] - 8'd1;
          end
        end
      end
    end
  end

  // Unsaturated sum of channel amplitudes.
  always_comb begin
    mix = '0;
    for (int c = 0; c < NUM_CH; c++) mix = mix + OUT_W'(amp[c]);
  end

  // Registered mixer output.
  always_ff @(posedge phi2) begin
    if (reset) aud <= '0;
    else       aud <= mix;
  end

endmodule

// File: tb/tb_pokey_audio_n.sv
// Bench for pokey_audio_n: table-driven register vectors, directed timing
// sequences and a randomized bus phase checked against a reference model.
module tb_pokey_audio_n;
  localparam int NUM_CH   = 4;
  localparam int BASE_DIV = 28;
  localparam int ADDR_W   = 4;
  localparam int OUT_W    = 7;
  localparam int LEN      = 16384;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cs_n = 1'b1;
  logic              r_w_n = 1'b1;
  logic [ADDR_W-1:0] a = '0;
  logic [7:0]        d_in = '0;
  logic [7:0]        d_out;
  logic [OUT_W-1:0]  aud;

  always #5 clk = ~clk;

  pokey_audio_n #(.NUM_CH(NUM_CH), .BASE_DIV(BASE_DIV), .ADDR_W(ADDR_W), .OUT_W(OUT_W)) dut (
    .phi2(clk), .reset(reset), .cs_n(cs_n), .r_w_n(r_w_n),
    .a(a), .d_in(d_in), .d_out(d_out), .aud(aud)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Poly output bit sequences from the all-ones seed, indexed by cycles since reset.
  bit s4 [LEN];
  bit s5 [LEN];
  bit s9 [LEN];
  bit s17 [LEN];

  // Reference model state.
  logic [7:0] m_audf [NUM_CH];
  logic [7:0] m_audc [NUM_CH];
  logic [7:0] m_ctl;
  int         m_cnt [NUM_CH];
  bit         m_tone [NUM_CH];
  int         t = 0;
  int         exp_aud = 0;
  logic [7:0] exp_dout = '0;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] rexp;
  } vec_t;
  vec_t vt [11];

  task automatic check(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, req, req, $time);
    end
  endtask

  function automatic logic [7:0] rnd_at(input int idx, input bit use9);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = use9 ? s9[idx + i] : s17[idx + i];
    return v;
  endfunction

  function automatic logic [7:0] m_read(input logic [3:0] ad);
    if (ad < 4'd8) return ad[0] ? m_audc[ad >> 1] : m_audf[ad >> 1];
    if (ad == 4'd8) return m_ctl;
    if (ad == 4'd9) return rnd_at(t, m_ctl[7]);
    return 8'h00;
  endfunction

  // Advances the model by one phi2 edge using the inputs presently driven.
  task automatic model_edge();
    int         na;
    logic [7:0] nd;
    bit         base, big, g;
    if (t + 16 >= LEN) begin
      $display("FAIL model_range: got t=%0d required below %0d", t, LEN - 16);
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "model range exceeded");
    end
    if (reset) begin
      m_ctl = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_audf[c] = '0; m_audc[c] = '0; m_cnt[c] = 0; m_tone[c] = 0;
      end
      t = 0; exp_aud = 0; exp_dout = '0;
      return;
    end
    nd = exp_dout;
    if (!cs_n && r_w_n) nd = m_read(a);
    na = 0;
    for (int c = 0; c < NUM_CH; c++)
      if (m_audc[c][4] || m_tone[c]) na += int'(m_audc[c][3:0]);
    base = ((t % BASE_DIV) == BASE_DIV - 1);
    big  = m_ctl[7] ? s9[t] : s17[t];
    for (int c = 0; c < NUM_CH; c++) begin
      if (m_ctl[c] || base) begin
        if (m_cnt[c] == 0) begin
          m_cnt[c] = int'(m_audf[c]);
          g = m_audc[c][5] || ((m_audc[c][7] || s5[t]) && (m_audc[c][6] ? s4[t] : big));
          if (g) m_tone[c] = !m_tone[c];
        end else begin
          m_cnt[c]--;
        end
      end
    end
    if (!cs_n && !r_w_n) begin
      if (a < 4'd8) begin
        if (a[0]) m_audc[a >> 1] = d_in;
        else      m_audf[a >> 1] = d_in;
      end else if (a == 4'd8) begin
        m_ctl = d_in;
      end
    end
    exp_aud = na; exp_dout = nd; t++;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] ad, input logic [7:0] dv);
    cs_n = 1'b0; r_w_n = 1'b0; a = ad; d_in = dv;
    step();
    cs_n = 1'b1; r_w_n = 1'b1;
  endtask

  task automatic rd(input logic [3:0] ad, output logic [7:0] v);
    cs_n = 1'b0; r_w_n = 1'b1; a = ad;
    step();
    v = d_out;
    cs_n = 1'b1;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
  endtask

  task automatic wait_change(output int n);
    logic [OUT_W-1:0] v;
    v = aud;
    n = 0;
    do begin
      step();
      n++;
    end while (aud == v && n < 200);
  endtask

  initial begin
    logic [7:0] v, e, prev;
    int n, lv;

    for (int i = 0; i < LEN; i++) begin
      s4[i]  = (i < 4)  ? 1'b1 : s4[i-1]  ^ s4[i-4];
      s5[i]  = (i < 5)  ? 1'b1 : s5[i-2]  ^ s5[i-5];
      s9[i]  = (i < 9)  ? 1'b1 : s9[i-5]  ^ s9[i-9];
      s17[i] = (i < 17) ? 1'b1 : s17[i-5] ^ s17[i-17];
    end

    vt[0]  = '{4'd0,  8'h12, 8'h12};
    vt[1]  = '{4'd1,  8'h3C, 8'h3C};
    vt[2]  = '{4'd2,  8'h5A, 8'h5A};
    vt[3]  = '{4'd5,  8'hC7, 8'hC7};
    vt[4]  = '{4'd6,  8'hFF, 8'hFF};
    vt[5]  = '{4'd7,  8'h00, 8'h00};
    vt[6]  = '{4'd8,  8'h8A, 8'h8A};
    vt[7]  = '{4'd10, 8'hFF, 8'h00};
    vt[8]  = '{4'd13, 8'h55, 8'h00};
    vt[9]  = '{4'd15, 8'hAA, 8'h00};
    vt[10] = '{4'd4,  8'h81, 8'h81};

    reset_dut();
    check("reset_aud", int'(aud), 0);
    check("reset_dout", int'(d_out), 0);

    // Register write/readback vectors.
    for (int i = 0; i < 11; i++) begin
      wr(vt[i].addr, vt[i].wdata);
      rd(vt[i].addr, v);
      check($sformatf("vec%0d_read", i), int'(v), int'(vt[i].rexp));
    end
    rd(4'd0, v);
    check("vec_audf0_kept", int'(v), 8'h12);

    // Volume-only channels summed one cycle after each commit.
    reset_dut();
    for (int c = 0; c < NUM_CH; c++) begin
      wr(4'(2 * c + 1), 8'h1F);
      step();
      check($sformatf("vol_sum_ch%0d", c), int'(aud), 15 * (c + 1));
    end

    // Reset during activity clears outputs and registers.
    rd(4'd1, v);
    check("pre_reset_dout", int'(v), 8'h1F);
    reset = 1'b1;
    step();
    check("mid_reset_aud", int'(aud), 0);
    check("mid_reset_dout", int'(d_out), 0);
    step(); step();
    reset = 1'b0;
    for (int ad = 0; ad <= 8; ad++) begin
      rd(4'(ad), v);
      check($sformatf("post_reset_reg%0d", ad), int'(v), 0);
    end

    // Fast-clock pure tone, AUDF=3: 4 cycles per level.
    reset_dut();
    wr(4'd8, 8'h01);
    wr(4'd0, 8'd3);
    wr(4'd1, 8'hA8);
    wait_change(n);
    wait_change(n);
    for (int k = 0; k < 3; k++) begin
      lv = int'(aud);
      wait_change(n);
      check("fast_run", n, 4);
      check("fast_levels", int'(aud) + lv, 8);
    end
    // AUDF change mid-count: current half-period unaffected, later ones 8 cycles.
    wr(4'd0, 8'd7);
    wait_change(n);
    check("audf_change_cur", n, 3);
    for (int k = 0; k < 2; k++) begin
      lv = int'(aud);
      wait_change(n);
      check("audf_change_new", n, 8);
      check("audf_change_lvl", int'(aud) + lv, 8);
    end

    // Base-tick tone with AUDF=0: one toggle per BASE_DIV cycles.
    reset_dut();
    wr(4'd8, 8'h00);
    wr(4'd0, 8'd0);
    wr(4'd1, 8'hA5);
    wait_change(n);
    wait_change(n);
    for (int k = 0; k < 2; k++) begin
      lv = int'(aud);
      wait_change(n);
      check("base_run", n, BASE_DIV);
      check("base_levels", int'(aud) + lv, 5);
    end

    // RANDOM readback follows poly17 from the all-ones seed.
    reset_dut();
    cs_n = 1'b0; r_w_n = 1'b1; a = 4'd9;
    prev = '0;
    for (int i = 0; i < 24; i++) begin
      e = rnd_at(t, 1'b0);
      step();
      if (i == 0) check("random_first", int'(d_out), 8'hFF);
      check("random_seq", int'(d_out), int'(e));
      if (i > 0) check("random_shift", int'(d_out[6:0]), int'(prev[7:1]));
      prev = d_out;
    end
    cs_n = 1'b1;
    wr(4'd2, 8'h5A);
    rd(4'd2, v);
    check("audf1_readback", int'(v), 8'h5A);

    // Randomized bus traffic against the model.
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      int op;
      logic [3:0] ad;
      op = $urandom_range(0, 9);
      ad = 4'($urandom_range(0, 15));
      reset = ($urandom_range(0, 299) == 0);
      if (op < 4) begin
        cs_n = 1'b1; r_w_n = 1'($urandom_range(0, 1));
      end else if (op < 7) begin
        cs_n = 1'b0; r_w_n = 1'b0;
        d_in = (ad < 4'd8 && !ad[0]) ? 8'($urandom_range(0, 5)) : 8'($urandom);
      end else begin
        cs_n = 1'b0; r_w_n = 1'b1;
      end
      a = ad;
      step();
      check("rand_aud", int'(aud), exp_aud);
      check("rand_dout", int'(d_out), int'(exp_dout));
    end
    reset = 1'b0; cs_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
